// File: rtl/regfile_pairs_if.sv
// Bus between the decoder/control unit and the regfile_pairs register file:
// single-register read/write, register-pair operations, pair read port and debug view.
interface regfile_pairs_if #(
  parameter int DATA_W = 8
);
  logic                  wr_en;
  logic                  mov_en;
  logic [2:0]            wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            rd_addr1;
  logic [2:0]            rd_addr2;
  logic [DATA_W-1:0]     rd_data1;
  logic [DATA_W-1:0]     rd_data2;
  logic                  pair_op_valid;
  logic [1:0]            pair_op;
  logic [1:0]            pair_sel;
  logic                  pair_busy;
  logic                  pair_done;
  logic [1:0]            pair_rd_sel;
  logic [2*DATA_W-1:0]   pair_rd_data;
  logic                  bank_swap;
  logic [8*DATA_W-1:0]   debug_regs_flat;

  modport master (
    output wr_en, mov_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output pair_op_valid, pair_op, pair_sel, pair_rd_sel, bank_swap,
    input  rd_data1, rd_data2, pair_busy, pair_done, pair_rd_data, debug_regs_flat
  );

  modport slave (
    input  wr_en, mov_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  pair_op_valid, pair_op, pair_sel, pair_rd_sel, bank_swap,
    output rd_data1, rd_data2, pair_busy, pair_done, pair_rd_data, debug_regs_flat
  );
endinterface

// File: rtl/regfile_pairs.sv
// 8085-style register file (B,C,D,E,H,L,M-slot,A) with sequenced INX/DCX/XCHG pair ops.
// Optional shadow bank for indices 0-5 enabled by defining REGFILE_SHADOW_BANK_EN.
module regfile_pairs #(
  parameter int          DATA_W      = 8,
  parameter int unsigned A_RESET     = 8'h03,
  parameter int unsigned OTHER_RESET = 0
) (
  input  logic            clk,
  input  logic            rst,
  regfile_pairs_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  typedef logic [5:0][DATA_W-1:0] bank_t;

  localparam logic [1:0]        OP_INX   = 2'b00;
  localparam logic [1:0]        OP_DCX   = 2'b01;
  localparam logic [1:0]        OP_XCHG  = 2'b10;
  localparam logic [DATA_W-1:0] A_RST    = DATA_W'(A_RESET);
  localparam bank_t             BANK_RST = {6{DATA_W'(OTHER_RESET)}};

  function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] idx, input bank_t view,
                                                 input logic [DATA_W-1:0] a);
    if (idx == 3'd7)      return a;
    else if (idx == 3'd6) return '0;
    else                  return view[idx];
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d, sel_q, sel_d;
  logic              carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] a_q, a_d;
  bank_t             bank0_q, bank0_d, cur, nxt;
  logic [DATA_W-1:0] wval, cext;
  logic [5:0]        lock;
  logic [2:0]        hi_i, lo_i;

`ifdef REGFILE_SHADOW_BANK_EN
  bank_t bank1_q, bank1_d;
  logic  act_q, act_d;
  assign cur = act_q ? bank1_q : bank0_q;
`else
  logic unused_bank_swap;
  assign unused_bank_swap = bus.bank_swap;
  assign cur = bank0_q;
`endif

  // High register sits at the even index of a pair, low at the odd one.
  assign hi_i = {sel_q, 1'b0};
  assign lo_i = {sel_q, 1'b1};
  assign cext = {{(DATA_W-1){1'b0}}, carry_q};

  always_comb begin
    nxt     = cur;
    a_d     = a_q;
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    carry_d = carry_q;
    lock    = '0;
    if (state_q != IDLE && sel_q != 2'b11) begin
      lock[hi_i] = 1'b1;
      lock[lo_i] = 1'b1;
    end
    if (state_q == IDLE && bus.pair_op_valid && bus.pair_op == OP_XCHG) lock[5:2] = '1;

    wval = bus.mov_en ? read_reg(bus.rd_addr1, cur, a_q) : bus.wr_data;
    if (bus.wr_en) begin
      if (bus.wr_addr == 3'd7) a_d = wval;
      else if (bus.wr_addr != 3'd6 && !lock[bus.wr_addr]) nxt[bus.wr_addr] = wval;
    end

    case (state_q)
      IDLE: begin
        if (bus.pair_op_valid) begin
          case (bus.pair_op)
            OP_INX, OP_DCX: begin
              if (bus.pair_sel != 2'b11) begin
                op_d    = bus.pair_op;
                sel_d   = bus.pair_sel;
                state_d = LOW;
              end
            end
            OP_XCHG: begin
              nxt[2]  = cur[4];
              nxt[3]  = cur[5];
              nxt[4]  = cur[2];
              nxt[5]  = cur[3];
              sel_d   = 2'b11;
              state_d = DONE;
            end
            default: ;
          endcase
        end
      end
      LOW: begin
        nxt[lo_i] = (op_q == OP_INX) ? cur[lo_i] + DATA_W'(1) : cur[lo_i] - DATA_W'(1);
        carry_d   = (op_q == OP_INX) ? (&cur[lo_i]) : ~(|cur[lo_i]);
        state_d   = HIGH;
      end
      HIGH: begin
        nxt[hi_i] = (op_q == OP_INX) ? cur[hi_i] + cext : cur[hi_i] - cext;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

`ifdef REGFILE_SHADOW_BANK_EN
    act_d = act_q;
    if (state_q == IDLE && !bus.pair_op_valid && bus.bank_swap) act_d = ~act_q;
    bank0_d = act_q ? bank0_q : nxt;
    bank1_d = act_q ? nxt : bank1_q;
`else
    bank0_d = nxt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_INX;
      sel_q   <= 2'b11;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= A_RST;
      bank0_q <= BANK_RST;
`ifdef REGFILE_SHADOW_BANK_EN
      bank1_q <= BANK_RST;
      act_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      bank0_q <= bank0_d;
`ifdef REGFILE_SHADOW_BANK_EN
      bank1_q <= bank1_d;
      act_q   <= act_d;
`endif
    end
  end

  assign bus.rd_data1        = read_reg(bus.rd_addr1, cur, a_q);
  assign bus.rd_data2        = read_reg(bus.rd_addr2, cur, a_q);
  assign bus.pair_busy       = busy_q;
  assign bus.pair_done       = done_q;
  assign bus.pair_rd_data    = (bus.pair_rd_sel == 2'b11) ? '0 :
                               {cur[{bus.pair_rd_sel, 1'b0}], cur[{bus.pair_rd_sel, 1'b1}]};
  assign bus.debug_regs_flat = {a_q, {DATA_W{1'b0}}, cur[5], cur[4], cur[3], cur[2], cur[1], cur[0]};
endmodule

// File: doc/regfile_pairs.md
Name: regfile_pairs

Overview:
- Parametrised successor to the 8085 general register file: B, C, D, E, H, L, (M slot), A, all DATA_W wide.
- Adds 16-bit register-pair operations: INX and DCX as a two-cycle low/high sequenced add with carry, and XCHG (DE<->HL), sequenced by a small FSM with busy/done handshake.
- Sits between the decoder/control unit and the ALU/memory-address path; pair read port feeds address generation.

Parameters:
- DATA_W, 8, register width; pair width is 2*DATA_W.
- A_RESET, 8'h03, reset value of A (index 7), zero-extended/truncated to DATA_W.
- OTHER_RESET, 0, reset value of indices 0-5.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  register write strobe.
- mov_en  in  1  with wr_en: regs[wr_addr] <= regs[rd_addr1] (register-to-register MOV).
- wr_addr  in  3  destination index (0=B .. 5=L, 6=M unmapped, 7=A).
- wr_data  in  DATA_W  write data when mov_en=0.
- rd_addr1, rd_addr2  in  3 each  read indices.
- rd_data1, rd_data2  out  DATA_W each  combinational read data.
- pair_op_valid  in  1  request a pair operation.
- pair_op  in  2  00 INX, 01 DCX, 10 XCHG, 11 reserved.
- pair_sel  in  2  00 BC, 01 DE, 10 HL, 11 reserved (ignored for XCHG).
- pair_busy  out  1  FSM not IDLE.
- pair_done  out  1  one-cycle completion pulse.
- pair_rd_sel  in  2  pair read select (00 BC, 01 DE, 10 HL, 11 returns 0).
- pair_rd_data  out  2*DATA_W  {high,low} of selected pair, combinational.
- bank_swap  in  1  shadow bank toggle (see Optional Feature).
- debug_regs_flat  out  8*DATA_W  {A,0,L,H,E,D,C,B} of active bank.

Behaviour:
- Reset: regs 0-5 = OTHER_RESET, A = A_RESET, FSM IDLE, pair_busy=0, pair_done=0, carry latch 0, active bank 0.
- Index 6: reads return 0; writes ignored (memory path handles M).
- Writes: on clk rise with wr_en: mov_en=1 copies regs[rd_addr1] to regs[wr_addr], else wr_data. Single-cycle latency; a same-cycle read returns the old value.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: pair_op_valid with a valid op/sel is accepted.
  - INX/DCX: latch op and sel, go LOW.
  - XCHG: swap D<->H and E<->L at the accept edge, go DONE.
  - Reserved op, or sel=11 with INX/DCX: ignored, stay IDLE, no done pulse.
- LOW: low <= low +/- 1 (mod 2^DATA_W); latch carry (INX: low==all-ones; DCX borrow: low==0); go HIGH.
- HIGH: high <= high +/- carry; go DONE.
- DONE: pair_done=1 for one cycle; go IDLE. pair_busy=1 in LOW, HIGH and DONE.
- INX/DCX latency: done visible in the 3rd cycle after the accept edge. Wrap-around: FFFF+1=0000, 0000-1=FFFF.
- pair_op_valid while busy: ignored (not queued).
- Conflicts:
  - While busy, wr_en targeting a register of the latched pair (or D/E/H/L at the XCHG accept edge) is dropped; the FSM wins.
  - Writes to other registers proceed normally.
- Intermediate reads: visible during LOW/HIGH (low updated before high).
- Reset mid-operation: FSM returns to IDLE immediately; registers take reset values; no done pulse.

Optional Feature:
- REGFILE_SHADOW_BANK_EN.
- Defined: a second bank of indices 0-5 exists, reset to OTHER_RESET; A is shared.
  - bank_swap high at a clk edge while IDLE and no pair_op_valid toggles the active bank.
  - bank_swap while busy or coincident with pair_op_valid is ignored.
  - All reads, writes, pair ops and debug_regs_flat use the active bank.
- Undefined: single bank; bank_swap ignored; the port remains.

Test Plan:
- Reset with DATA_W=8 -> debug_regs_flat = 64'h03000000_00000000, pair_busy=0, rd_data1 at index 6 = 0.
- Write B=8'h12, then MOV C<-B (wr_en, mov_en, rd_addr1=0, wr_addr=1) -> C=8'h12 next cycle; write to index 6 leaves state unchanged.
- HL=16'h00FF, INX HL -> busy for 3 cycles, L=00 then H=01, pair_done pulse, pair_rd_data=16'h0100; BC=0000, DCX BC -> FFFF.
- DE=1234, HL=ABCD, XCHG -> DE=ABCD, HL=1234, done one cycle after accept; second pair_op_valid while busy ignored.
- INX DE while wr_en writes E=8'h55 during LOW -> E write dropped, DE = old+1; concurrent write to B succeeds.
- INX HL, assert rst during HIGH -> all regs at reset values, FSM IDLE, no pair_done; with REGFILE_SHADOW_BANK_EN, write B=AA, swap, B reads 00, swap back, B=AA.
